// File: rtl/prod_accum_pkg.sv
// Shared types and default widths for the product accumulator.
package prod_accum_pkg;

    localparam int unsigned PROD_W_DEF = 32;
    localparam int unsigned ACC_W_DEF  = 40;
    localparam int unsigned LEN_W_DEF  = 9;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

endpackage

// File: rtl/prod_accum.sv
// Accumulates a burst of LEN unsigned products into a wide sum and offers the
// result on a valid/ready handshake, with a sticky overflow flag.
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              prod_valid_i,
    output logic              prod_ready_o,
    output logic [ACC_W-1:0]  acc_o,
    output logic              acc_valid_o,
    input  logic              acc_ready_i,
    output logic              busy_o,
    output logic              ovf_o
);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovf_q, ovf_d;
    logic               xfer;
    logic               last;
    logic [ACC_W:0]     sum;

    assign xfer = prod_valid_i && (state_q == ACCUM);
    // len_q is never zero in ACCUM, so len_q-1 cannot underflow and cnt_q never wraps
    assign last = (cnt_q == (len_q - 1'b1));
    assign sum  = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start_i && (len_i != '0)) begin
                    state_d = ACCUM;
                    len_d   = len_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACCUM: begin
                if (xfer) begin
                    acc_d = sum[ACC_W-1:0];
                    ovf_d = ovf_q | sum[ACC_W];
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (acc_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    assign prod_ready_o = (state_q == ACCUM);
    assign acc_valid_o  = (state_q == HOLD);
    assign busy_o       = (state_q != IDLE);
    assign acc_o        = acc_q;
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: a 40-bit and a 33-bit accumulator share one stimulus stream.
module tb_prod_accum;

    logic        clk;
    logic        rst_ni;
    logic        start_i;
    logic [8:0]  len_i;
    logic [31:0] prod_i;
    logic        prod_valid_i;
    logic        acc_ready_i;

    logic        prod_ready_o, acc_valid_o, busy_o, ovf_o;
    logic [39:0] acc_o;
    logic        prod_ready33, acc_valid33, busy33, ovf33;
    logic [32:0] acc33;

    prod_accum dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
        .prod_i(prod_i), .prod_valid_i(prod_valid_i), .prod_ready_o(prod_ready_o),
        .acc_o(acc_o), .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i),
        .busy_o(busy_o), .ovf_o(ovf_o)
    );

    prod_accum #(.ACC_W(33)) dut33 (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
        .prod_i(prod_i), .prod_valid_i(prod_valid_i), .prod_ready_o(prod_ready33),
        .acc_o(acc33), .acc_valid_o(acc_valid33), .acc_ready_i(acc_ready_i),
        .busy_o(busy33), .ovf_o(ovf33)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          len;
        int          gap;
        int          hold;
        logic [31:0] p [8];
        logic [39:0] exp_acc;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        logic [39:0] acc40;
        logic        ovf40;
        logic [32:0] acc33;
        logic        ovf33;
    } exp_t;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] vals [$];
    exp_t        sb [$];
    vec_t        tbl [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact sum in 64 bits, then truncate per accumulator width.
    function automatic exp_t model_of_vals();
        exp_t        e;
        logic [63:0] s;
        s = '0;
        foreach (vals[i]) s = s + {32'd0, vals[i]};
        e.acc40 = s[39:0];
        e.ovf40 = |s[63:40];
        e.acc33 = s[32:0];
        e.ovf33 = |s[63:33];
        return e;
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_acc"},   acc_o, 0);
        chk({tag, "_acc33"}, acc33, 0);
        chk({tag, "_flags"}, {busy_o, prod_ready_o, acc_valid_o, ovf_o,
                              busy33, prod_ready33, acc_valid33, ovf33}, 0);
    endtask

    // Start a burst, feed vals with gap idle cycles between products,
    // then consume the result after hold stalled HOLD cycles.
    task automatic run_burst(input int gap, input int hold, input exp_t e);
        int   t;
        exp_t got;
        start_i = 1'b1;
        len_i   = 9'(vals.size());
        @(negedge clk);
        start_i = 1'b0;
        len_i   = '0;
        chk("ready_in_accum", {busy_o, prod_ready_o, acc_valid_o}, 3'b110);
        for (int k = 0; k < vals.size(); k++) begin
            prod_i       = vals[k];
            prod_valid_i = 1'b1;
            if (k == vals.size() - 1) sb.push_back(e);
            @(negedge clk);
            prod_valid_i = 1'b0;
            prod_i       = 32'hDEAD_BEEF;
            if (k != vals.size() - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    chk("gap_no_result", {prod_ready_o, acc_valid_o}, 2'b10);
                end
            end
        end
        t = 0;
        while (!acc_valid_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("result_latency", t, 0);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
            return;
        end
        got = sb.pop_front();
        chk("acc_o",       acc_o, got.acc40);
        chk("ovf_o",       ovf_o, got.ovf40);
        chk("acc33",       acc33, got.acc33);
        chk("ovf33",       ovf33, got.ovf33);
        chk("hold_flags",  {busy_o, prod_ready_o, acc_valid33}, 3'b101);
        for (int h = 0; h < hold; h++) begin
            start_i      = h[0];
            len_i        = 9'd3;
            prod_valid_i = 1'b1;
            prod_i       = 32'h0000_1234;
            @(negedge clk);
            chk("hold_acc_stable", acc_o, got.acc40);
            chk("hold_valid",      {acc_valid_o, prod_ready_o, ovf_o}, {2'b10, got.ovf40});
        end
        start_i      = 1'b0;
        len_i        = '0;
        prod_valid_i = 1'b0;
        acc_ready_i  = 1'b1;
        @(negedge clk);
        acc_ready_i  = 1'b0;
        chk("back_to_idle", {busy_o, acc_valid_o, busy33}, 3'b000);
        chk("idle_keeps_acc", acc_o, got.acc40);
        chk("idle_keeps_ovf", ovf_o, got.ovf40);
    endtask

    initial begin
        exp_t e;
        rst_ni = 1'b0; start_i = 1'b0; len_i = '0; prod_i = '0;
        prod_valid_i = 1'b0; acc_ready_i = 1'b0;

        tbl[0] = '{len: 4, gap: 0, hold: 0, p: '{1, 2, 3, 4, 0, 0, 0, 0},
                   exp_acc: 40'd10, exp_ovf: 1'b0};
        tbl[1] = '{len: 3, gap: 2, hold: 0,
                   p: '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0},
                   exp_acc: 40'h2_FFFF_FFFD, exp_ovf: 1'b0};
        tbl[2] = '{len: 2, gap: 1, hold: 5, p: '{5, 32'h10, 0, 0, 0, 0, 0, 0},
                   exp_acc: 40'h15, exp_ovf: 1'b0};
        tbl[3] = '{len: 1, gap: 0, hold: 2, p: '{7, 0, 0, 0, 0, 0, 0, 0},
                   exp_acc: 40'd7, exp_ovf: 1'b0};
        tbl[4] = '{len: 8, gap: 0, hold: 1, p: '{8{32'h8000_0000}},
                   exp_acc: 40'h4_0000_0000, exp_ovf: 1'b0};

        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst_ni = 1'b1;
        @(negedge clk);

        // Reset lands after 3 of 5 products: everything must clear asynchronously.
        start_i = 1'b1; len_i = 9'd5;
        @(negedge clk);
        start_i = 1'b0; len_i = '0;
        for (int k = 0; k < 3; k++) begin
            prod_i = 32'd100 + k; prod_valid_i = 1'b1;
            @(negedge clk);
        end
        prod_valid_i = 1'b0;
        chk("pre_reset_partial", acc_o, 40'd303);
        #2 rst_ni = 1'b0;
        #1 check_idle_zero("mid_reset");
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        check_idle_zero("post_reset");

        for (int i = 0; i < 5; i++) begin
            vals.delete();
            for (int k = 0; k < tbl[i].len; k++) vals.push_back(tbl[i].p[k]);
            e       = model_of_vals();
            e.acc40 = tbl[i].exp_acc;
            e.ovf40 = tbl[i].exp_ovf;
            run_burst(tbl[i].gap, tbl[i].hold, e);
        end

        // Zero-length start is ignored; stray product valid in IDLE has no effect.
        start_i = 1'b1; len_i = '0; prod_valid_i = 1'b1; prod_i = 32'h55;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        prod_valid_i = 1'b0;
        chk("len0_idle", {busy_o, prod_ready_o, acc_valid_o}, 3'b000);
        chk("idle_prod_ignored", acc_o, 40'h4_0000_0000);
        chk("idle_ovf33_kept", ovf33, 1'b1);

        vals.delete();
        vals.push_back(32'd7);
        run_burst(0, 0, model_of_vals());

        // Maximum length with all-ones products overflows the 40-bit sum.
        vals.delete();
        for (int k = 0; k < 511; k++) vals.push_back(32'hFFFF_FFFF);
        e = model_of_vals();
        chk("max_len_model_ovf", e.ovf40, 1'b1);
        run_burst(0, 1, e);

        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
